// File: rtl/button_pulse_conditioner_pkg.sv
// Shared definitions for the button conditioner: FSM encoding and a
// ceiling-log2 helper used to sanity-check counter widths at elaboration.
package button_pulse_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_REPEAT = 2'd1,
    REPEAT      = 2'd2
  } state_t;

  function automatic int clog2(input longint unsigned v);
    int r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_pulse_conditioner_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Debounces a raw push-button and emits one-cycle count pulses per press,
// plus hold-to-repeat pulses while the button stays down.
module button_pulse_conditioner
  import button_pulse_conditioner_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic pulse,
  output logic held
);

  localparam longint unsigned MAX_A = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
  localparam longint unsigned MAX_V = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;

  if (CNT_W < clog2(MAX_V + 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             btn_sync;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] rp_cnt;
  logic [CNT_W-1:0] rp_cnt_nxt;
  logic             db_done;
  logic             level_rise;
  logic             level_fall;
  logic             pulse_nxt;
  state_t           state;
  state_t           state_nxt;

  sync_2ff u_sync (
    .clk  (CLK),
    .rst_n(reset_n),
    .d    (btn_raw),
    .q    (btn_sync)
  );

  // The FSM reacts on the same edge btn_level toggles, so the toggle is decoded combinationally.
  assign db_done    = (btn_sync != btn_level) && (db_cnt == DB_LAST);
  assign level_rise = db_done && btn_sync;
  assign level_fall = db_done && !btn_sync;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (btn_sync == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_level <= btn_sync;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    rp_cnt_nxt = rp_cnt;
    pulse_nxt  = 1'b0;
    if (level_fall) begin
      state_nxt  = IDLE;
      rp_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (level_rise) begin
            pulse_nxt  = 1'b1;
            rp_cnt_nxt = '0;
            state_nxt  = WAIT_REPEAT;
          end
        end
        WAIT_REPEAT: begin
          if (REPEAT_DELAY == 0) begin
            rp_cnt_nxt = '0;
          end else if (rp_cnt == RD_LAST) begin
            pulse_nxt  = 1'b1;
            rp_cnt_nxt = '0;
            state_nxt  = REPEAT;
          end else begin
            rp_cnt_nxt = rp_cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (rp_cnt == RP_LAST) begin
            pulse_nxt  = 1'b1;
            rp_cnt_nxt = '0;
          end else begin
            rp_cnt_nxt = rp_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt  = IDLE;
          rp_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rp_cnt <= '0;
      pulse  <= 1'b0;
      held   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rp_cnt <= rp_cnt_nxt;
      pulse  <= pulse_nxt;
      held   <= (state_nxt == REPEAT);
    end
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner: vector table of press scenarios with a
// pulse-time scoreboard and level/held windows derived from the timing rules.
module tb_button_pulse_conditioner;

  localparam int S  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int W  = 8;
  localparam int NV = 9;

  logic CLK = 1'b0;
  logic reset_n;
  logic btn_raw;
  logic btn_level;
  logic pulse;
  logic held;

  typedef struct {
    int bounce;
    int glitch;
    int hold;
    int exp_pulses;
  } vec_t;

  vec_t vecs[NV];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   npulse = 0;
  int   lvl_on = 0, lvl_off = 0, held_on = 0, held_off = 0;
  bit   mon_en = 1'b1;
  int   q[$];

  button_pulse_conditioner #(
    .STABLE_CYCLES(S),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .CNT_W        (W)
  ) dut (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .pulse    (pulse),
    .held     (held)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // cyc numbers the rising edge whose results are sampled 1 ns later.
  always @(posedge CLK) begin
    int e;
    cyc = cyc + 1;
    #1;
    if (mon_en) begin
      check("btn_level", int'(btn_level), int'(cyc >= lvl_on && cyc < lvl_off));
      check("held", int'(held), int'(cyc >= held_on && cyc < held_off));
      if (pulse) begin
        npulse++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pulse_unexpected cyc=%0d actual=1 required=0", cyc);
        end else begin
          e = q.pop_front();
          check("pulse_time", cyc, e);
        end
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int c, p, f, base;
    base = npulse;
    if (v.bounce != 0) begin
      for (int k = 0; k < 2; k++) begin
        btn_raw = 1'b1;
        repeat (2) @(negedge CLK);
        btn_raw = 1'b0;
        repeat (2) @(negedge CLK);
      end
    end
    if (v.glitch != 0) begin
      lvl_on = 0; lvl_off = 0; held_on = 0; held_off = 0;
      btn_raw = 1'b1;
      repeat (v.glitch) @(negedge CLK);
      btn_raw = 1'b0;
    end else begin
      c = cyc;
      p = c + S + 2;
      f = c + v.hold + S + 2;
      lvl_on = p; lvl_off = f; held_on = p + RD; held_off = f;
      q.push_back(p);
      for (int t = p + RD; t < f; t += RP) q.push_back(t);
      btn_raw = 1'b1;
      repeat (v.hold) @(negedge CLK);
      btn_raw = 1'b0;
    end
    repeat (S + 8) @(negedge CLK);
    check($sformatf("vec%0d_pulse_count", idx), npulse - base, v.exp_pulses);
  endtask

  initial begin
    int c, r, base;
    vecs[0] = '{bounce: 0, glitch: 0, hold: 10, exp_pulses: 1};
    vecs[1] = '{bounce: 1, glitch: 0, hold: 12, exp_pulses: 1};
    vecs[2] = '{bounce: 0, glitch: 3, hold: 0,  exp_pulses: 0};
    vecs[3] = '{bounce: 0, glitch: 1, hold: 0,  exp_pulses: 0};
    vecs[4] = '{bounce: 0, glitch: 0, hold: 60, exp_pulses: 6};
    vecs[5] = '{bounce: 0, glitch: 0, hold: 30, exp_pulses: 3};
    vecs[6] = '{bounce: 0, glitch: 0, hold: 21, exp_pulses: 2};
    vecs[7] = '{bounce: 0, glitch: 0, hold: 20, exp_pulses: 1};
    vecs[8] = '{bounce: 0, glitch: 0, hold: 4,  exp_pulses: 1};

    reset_n = 1'b0;
    btn_raw = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_btn_level", int'(btn_level), 0);
    check("reset_pulse", int'(pulse), 0);
    check("reset_held", int'(held), 0);
    reset_n = 1'b1;
    repeat (4) @(negedge CLK);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset while waiting for the first repeat, with the button still down.
    c = cyc;
    lvl_on = c + S + 2; lvl_off = 32'h7fffffff; held_on = 0; held_off = 0;
    q.push_back(c + S + 2);
    btn_raw = 1'b1;
    repeat (S + 2 + 5) @(negedge CLK);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_btn_level", int'(btn_level), 0);
    check("midreset_pulse", int'(pulse), 0);
    check("midreset_held", int'(held), 0);
    base = npulse;
    repeat (2) @(negedge CLK);
    r = cyc;
    lvl_on = r + S + 2; lvl_off = r + 10 + S + 2;
    q.push_back(r + S + 2);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (10) @(negedge CLK);
    btn_raw = 1'b0;
    repeat (S + 8) @(negedge CLK);
    check("reset_counter_increments", npulse - base, 1);

    check("pulses_outstanding", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
